// File: rtl/motor_cmd_seq_pkg.sv
// Shared encodings for the motor command sequencer and the downstream PWM driver.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOFT = 2'd1,
    RUN  = 2'd2,
    DEAD = 2'd3
  } state_t;

  // cmd bit positions seen by the driver
  localparam int EN   = 0;
  localparam int DIR  = 1;
  localparam int FAST = 2;

  // operator switch bit positions
  localparam int SW_RUN  = 0;
  localparam int SW_DIR  = 1;
  localparam int SW_FAST = 2;

  function automatic logic [2:0] mk_cmd(input logic en, input logic dir, input logic fast);
    logic [2:0] c;
    c       = '0;
    c[EN]   = en;
    c[DIR]  = dir;
    c[FAST] = fast;
    return c;
  endfunction

endpackage

// File: rtl/motor_cmd_seq_if.sv
// Switch inputs and driver-facing command/status of the motor command sequencer.
interface motor_cmd_seq_if;
  logic [2:0] sw_raw;
  logic [2:0] cmd;
  logic       busy;
  logic [1:0] state_o;

  modport master (output sw_raw, input cmd, input busy, input state_o);
  modport slave  (input sw_raw, output cmd, output busy, output state_o);
endinterface

// File: rtl/motor_cmd_seq_sw_debounce.sv
// Single-bit two-flop synchroniser followed by a consecutive-mismatch debounce counter.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // any agreement restarts the count, so short glitches never reach TC
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/motor_cmd_seq.sv
// Motor command sequencer: debounced switches drive a soft-start / run / dead-time
// sequence whose registered command feeds the PWM driver directly.
//
//   state | meaning
//   IDLE  | motor off, waiting for debounced run
//   SOFT  | enabled at low duty, direction latched
//   RUN   | enabled, fast duty follows debounced fast switch
//   DEAD  | motor de-energised for the dead-time before any restart
import motor_pkg::*;

module motor_cmd_seq #(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int SOFTSTART_CYCLES = 2000,
  parameter int DEADTIME_CYCLES  = 500,
  parameter int CNT_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  motor_cmd_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] SOFT_TC = CNT_W'(SOFTSTART_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_TC = CNT_W'(DEADTIME_CYCLES - 1);

  logic [2:0]       db;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             dir_l;
  logic [2:0]       cmd_q;
  logic             busy_q;
  logic             stop_req;

  for (genvar i = 0; i < 3; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (bus.sw_raw[i]),
      .dout(db[i])
    );
  end

  // run dropped or direction changed while energised
  assign stop_req = !db[SW_RUN] || (db[SW_DIR] != dir_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      dir_l  <= 1'b0;
      cmd_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (db[SW_RUN]) begin
            dir_l  <= db[SW_DIR];
            timer  <= '0;
            state  <= SOFT;
            cmd_q  <= mk_cmd(1'b1, db[SW_DIR], 1'b0);
            busy_q <= 1'b1;
          end else begin
            cmd_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        SOFT: begin
          if (stop_req) begin
            state  <= DEAD;
            timer  <= '0;
            cmd_q  <= '0;
            busy_q <= 1'b1;
          end else if (timer == SOFT_TC) begin
            state  <= RUN;
            cmd_q  <= mk_cmd(1'b1, dir_l, db[SW_FAST]);
            busy_q <= 1'b0;
          end else begin
            timer  <= timer + CNT_W'(1);
            cmd_q  <= mk_cmd(1'b1, dir_l, 1'b0);
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop_req) begin
            state  <= DEAD;
            timer  <= '0;
            cmd_q  <= '0;
            busy_q <= 1'b1;
          end else begin
            cmd_q  <= mk_cmd(1'b1, dir_l, db[SW_FAST]);
            busy_q <= 1'b0;
          end
        end
        DEAD: begin
          cmd_q <= '0;
          if (timer == DEAD_TC) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            timer  <= timer + CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cmd_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.busy    = busy_q;
  assign bus.state_o = state;

endmodule

// File: tb/tb_motor_cmd_seq.sv
// Randomised and directed bench for motor_cmd_seq against a phase/elapsed-time model.
module tb_motor_cmd_seq;

  localparam int D = 4;
  localparam int S = 5;
  localparam int T = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  motor_cmd_seq_if bus();

  motor_cmd_seq #(
    .DEBOUNCE_CYCLES (D),
    .SOFTSTART_CYCLES(S),
    .DEADTIME_CYCLES (T),
    .CNT_W           (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // model: switch history, debounced levels, phase (0 idle,1 soft,2 run,3 dead)
  // plus edges elapsed since the phase was entered
  logic [2:0] m_s1, m_s2, m_db;
  int         m_mis [3];
  int         m_phase;
  int         m_since;
  logic       m_dir;
  logic [2:0] m_cmd;

  task automatic model_step();
    logic stop;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int b = 0; b < 3; b++) m_mis[b] = 0;
      m_phase = 0; m_since = 0; m_dir = 1'b0;
    end else begin
      stop = !m_db[0] || (m_db[1] != m_dir);
      m_since++;
      case (m_phase)
        0: if (m_db[0]) begin m_dir = m_db[1]; m_phase = 1; m_since = 0; end
        1: if (stop) begin m_phase = 3; m_since = 0; end
           else if (m_since == S) m_phase = 2;
        2: if (stop) begin m_phase = 3; m_since = 0; end
        default: if (m_since == T) m_phase = 0;
      endcase
      case (m_phase)
        1:       m_cmd = {1'b0, m_dir, 1'b1};
        2:       m_cmd = {m_db[2], m_dir, 1'b1};
        default: m_cmd = 3'b000;
      endcase
      for (int b = 0; b < 3; b++) begin
        if (m_s2[b] != m_db[b]) begin
          m_mis[b]++;
          if (m_mis[b] == D) begin m_db[b] = m_s2[b]; m_mis[b] = 0; end
        end else begin
          m_mis[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.sw_raw;
    end
    if (rst) m_cmd = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("cmd", bus.cmd, m_cmd);
    check_val("state", {1'b0, bus.state_o}, 3'(m_phase));
    check_val("busy", {2'b00, bus.busy}, {2'b00, (m_phase == 1 || m_phase == 3)});
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    bus.sw_raw = v;
    repeat (n) tick();
  endtask

  initial begin
    m_cmd      = '0;
    rst        = 1'b1;
    bus.sw_raw = 3'b111;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    check_val("rel_e6", bus.cmd, 3'b000);
    tick();
    check_val("rel_e7", bus.cmd, 3'b011);
    hold(3'b000, 30);

    // glitch of 3 cycles rejected, 4 cycles accepted
    hold(3'b001, 3);
    hold(3'b000, 12);
    check_val("glitch3", bus.cmd, 3'b000);
    bus.sw_raw = 3'b001;
    repeat (4) tick();
    bus.sw_raw = 3'b000;
    repeat (2) tick();
    check_val("pulse4_e6", bus.cmd, 3'b000);
    tick();
    check_val("pulse4_e7", bus.cmd, 3'b001);
    hold(3'b000, 25);

    // soft-start into fast run, then reversal
    hold(3'b101, 7);
    check_val("soft_in", bus.cmd, 3'b001);
    hold(3'b101, 5);
    check_val("run_fast", bus.cmd, 3'b101);
    hold(3'b111, 7);
    check_val("rev_dead", bus.cmd, 3'b000);
    hold(3'b111, 20);
    check_val("rev_run", bus.cmd, 3'b111);

    // stop during soft-start, run re-asserted inside dead-time
    hold(3'b000, 30);
    hold(3'b001, 9);
    hold(3'b000, 8);
    hold(3'b001, 20);
    hold(3'b000, 30);

    // reset in RUN: immediate drop, fresh debounce on restart
    hold(3'b101, 20);
    check_val("pre_rst", bus.cmd, 3'b101);
    rst = 1'b1;
    tick();
    check_val("mid_rst", bus.cmd, 3'b000);
    rst = 1'b0;
    repeat (6) tick();
    check_val("rst_e6", bus.cmd, 3'b000);
    tick();
    check_val("rst_e7", bus.cmd, 3'b001);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      hold(3'($urandom_range(0, 7)), $urandom_range(1, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
